vram_march_tester: RTL and testbench

Parametrised VRAM bring-up engine, successor to the fixed two-lane byte-poke VRAM controller. It takes single-byte commands from the UART RX path and autonomously fills or verifies the whole VRAM address space with a reproducible pattern. It reports pass results as a byte stream to the UART TX path. It sits between the UART pair and the VRAM bidirectional pad buffers, with the PPUs held in reset.

---
 rtl/vram_march_tester.sv | 315 +++++++++++++++++++++++++++++++
 tb/tb_vram_march_tester.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/vram_march_tester.sv
// vram_march_tester
//   VRAM bring-up engine. Single-byte commands from the UART RX path start
//   fill / verify passes over the whole VRAM address space with a
//   reproducible pattern. Results go back as a byte stream to the UART TX path.
//
// Ports
//   clock, reset_n        system clock, synchronous active-low reset
//   cmd_data_i/valid_i    command byte and its one-cycle qualifier
//   rsp_data_o/valid_o    response byte and its one-cycle write strobe
//   rsp_busy_i            UART TX busy; holds off response emission
//   busy_o                pass or response emission in progress
//   error_o               sticky: verify mismatch or bad opcode seen
//   vrd_n_o, vwr_n_o      VRAM read strobe, per-lane write strobes
//   va_o, vd_o, vd_i      VRAM address, write data, read data (lane k = [8k+7:8k])
//   vd_tristate_o         1 = FPGA pads not driving
//   lvl_vd_dir_o          1 = level shifter FPGA->VRAM
//
// Build option
//   VRAM_MARCH_LFSR_EN    pattern comes from a 16-bit Galois LFSR (taps 0xB400)
//                         instead of the address-derived pattern.
module vram_march_tester #(
  parameter int ADDR_WIDTH    = 15,
  parameter int LANES         = 2,
  parameter int SETUP_CYCLES  = 2,
  parameter int STROBE_CYCLES = 4
) (
  input  logic                    clock,
  input  logic                    reset_n,
  input  logic [7:0]              cmd_data_i,
  input  logic                    cmd_valid_i,
  output logic [7:0]              rsp_data_o,
  output logic                    rsp_valid_o,
  input  logic                    rsp_busy_i,
  output logic                    busy_o,
  output logic                    error_o,
  output logic                    vrd_n_o,
  output logic [LANES-1:0]        vwr_n_o,
  output logic [ADDR_WIDTH-1:0]   va_o,
  output logic [8*LANES-1:0]      vd_o,
  input  logic [8*LANES-1:0]      vd_i,
  output logic                    vd_tristate_o,
  output logic                    lvl_vd_dir_o
);

  localparam int ADDR_BYTES = (ADDR_WIDTH + 7) / 8;
  localparam int CNT_MAX    = (SETUP_CYCLES > STROBE_CYCLES) ? SETUP_CYCLES : STROBE_CYCLES;
  localparam int CNT_W      = $clog2(CNT_MAX + 1);
  localparam logic [ADDR_WIDTH-1:0] ADDR_LAST = '1;

  typedef enum logic [2:0] {IDLE, SEED_HI, SEED_LO, SETUP, STROBE, HOLD, NEXT, RESP} state_t;
  // Response kind doubles as the pass kind while a pass is running.
  typedef enum logic [2:0] {K_FILL, K_VERIFY, K_BOTH, K_REPORT, K_BAD} rsp_kind_t;

  state_t                  state_reg;
  rsp_kind_t               rsp_kind_reg;
  logic [CNT_W-1:0]        cnt_reg;
  logic [ADDR_WIDTH-1:0]   addr_reg;
  logic                    verify_reg;
  logic [7:0]              seed_lo_reg;
  logic [15:0]             err_count_reg;
  logic [ADDR_WIDTH-1:0]   fail_addr_reg;
  logic                    fail_seen_reg;
  logic                    error_reg, busy_reg;
  logic                    rsp_valid_reg;
  logic [7:0]              rsp_data_reg;
  logic [2:0]              rsp_idx_reg;
  logic                    vrd_n_reg, vd_tri_reg, dir_reg;
  logic [LANES-1:0]        vwr_n_reg;
  logic [8*LANES-1:0]      vd_reg;

  // Pattern base byte for the current address, for address 0 at pass start,
  // and for the address about to be entered.
  logic [7:0] base_cur, base_start, base_next;

`ifdef VRAM_MARCH_LFSR_EN
  logic [7:0]  seed_hi_reg;
  logic [15:0] lfsr_reg, lfsr_start, lfsr_step;
  // An all-zero LFSR would lock up, so a zero seed maps to 0xACE1.
  assign lfsr_start = ({seed_hi_reg, seed_lo_reg} == 16'h0000) ? 16'hACE1 : {seed_hi_reg, seed_lo_reg};
  assign lfsr_step  = {1'b0, lfsr_reg[15:1]} ^ (lfsr_reg[0] ? 16'hB400 : 16'h0000);
  assign base_cur   = lfsr_reg[7:0];
  assign base_start = lfsr_start[7:0];
  assign base_next  = lfsr_step[7:0];
`else
  logic [7:0] addr8;
  generate
    if (ADDR_WIDTH >= 8) begin : g_a8_wide
      assign addr8 = addr_reg[7:0];
    end else begin : g_a8_narrow
      assign addr8 = {{(8-ADDR_WIDTH){1'b0}}, addr_reg};
    end
  endgenerate
  assign base_cur   = addr8 + seed_lo_reg;
  assign base_start = seed_lo_reg;
  assign base_next  = addr8 + seed_lo_reg + 8'd1;
`endif

  function automatic logic [8*LANES-1:0] pattern_from(input logic [7:0] base);
    logic [8*LANES-1:0] p;
    for (int k = 0; k < LANES; k++) p[8*k +: 8] = base + 8'(k);
    return p;
  endfunction

  logic [8*LANES-1:0] exp_data;
  logic [LANES-1:0]   lane_miss;
  assign exp_data = pattern_from(base_cur);

  genvar gi;
  generate
    for (gi = 0; gi < LANES; gi++) begin : g_cmp
      assign lane_miss[gi] = (vd_i[8*gi +: 8] != exp_data[8*gi +: 8]);
    end
  endgenerate

  // Response stream: length and byte at rsp_idx_reg for the pending kind.
  logic [2:0]                rsp_len;
  logic [7:0]                rsp_byte;
  logic [8*ADDR_BYTES-1:0]   fail_addr_pad;

  always_comb begin
    fail_addr_pad = '0;
    fail_addr_pad[ADDR_WIDTH-1:0] = fail_addr_reg;
    case (rsp_kind_reg)
      K_VERIFY: rsp_len = 3'd3;
      K_BOTH:   rsp_len = 3'd4;
      K_REPORT: rsp_len = 3'(ADDR_BYTES + 1);
      default:  rsp_len = 3'd1;
    endcase
    rsp_byte = 8'h00;
    case (rsp_kind_reg)
      K_FILL:   rsp_byte = 8'hF1;
      K_BAD:    rsp_byte = 8'hEE;
      K_VERIFY: rsp_byte = (rsp_idx_reg == 3'd0) ? 8'hF2 :
                           (rsp_idx_reg == 3'd1) ? err_count_reg[15:8] : err_count_reg[7:0];
      K_BOTH:   rsp_byte = (rsp_idx_reg == 3'd0) ? 8'hF1 :
                           (rsp_idx_reg == 3'd1) ? 8'hF2 :
                           (rsp_idx_reg == 3'd2) ? err_count_reg[15:8] : err_count_reg[7:0];
      K_REPORT: begin
        if (rsp_idx_reg == 3'd0) rsp_byte = 8'hF4;
        // fail_addr goes out MSB byte first after the header.
        for (int b = 0; b < ADDR_BYTES; b++)
          if (rsp_idx_reg == 3'(ADDR_BYTES - b)) rsp_byte = fail_addr_pad[8*b +: 8];
      end
      default:  rsp_byte = 8'h00;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_reg     <= IDLE;
      rsp_kind_reg  <= K_FILL;
      cnt_reg       <= '0;
      addr_reg      <= '0;
      verify_reg    <= 1'b0;
      seed_lo_reg   <= 8'h00;
      err_count_reg <= 16'h0000;
      fail_addr_reg <= '0;
      fail_seen_reg <= 1'b0;
      error_reg     <= 1'b0;
      busy_reg      <= 1'b0;
      rsp_valid_reg <= 1'b0;
      rsp_data_reg  <= 8'h00;
      rsp_idx_reg   <= 3'd0;
      vrd_n_reg     <= 1'b1;
      vwr_n_reg     <= '1;
      vd_reg        <= '0;
      vd_tri_reg    <= 1'b1;
      dir_reg       <= 1'b0;
`ifdef VRAM_MARCH_LFSR_EN
      seed_hi_reg   <= 8'h00;
      lfsr_reg      <= 16'hACE1;
`endif
    end else begin
      rsp_valid_reg <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (cmd_valid_i) begin
            case (cmd_data_i)
              8'h00: ;
              8'h01, 8'h02, 8'h03: begin
                busy_reg     <= 1'b1;
                addr_reg     <= '0;
                cnt_reg      <= '0;
                state_reg    <= SETUP;
                verify_reg   <= (cmd_data_i == 8'h02);
                rsp_kind_reg <= (cmd_data_i == 8'h01) ? K_FILL :
                                (cmd_data_i == 8'h02) ? K_VERIFY : K_BOTH;
                vd_tri_reg   <= (cmd_data_i == 8'h02);
                dir_reg      <= (cmd_data_i != 8'h02);
                vd_reg       <= (cmd_data_i == 8'h02) ? '0 : pattern_from(base_start);
                if (cmd_data_i == 8'h02) begin
                  err_count_reg <= 16'h0000;
                  fail_addr_reg <= '0;
                  fail_seen_reg <= 1'b0;
                end
`ifdef VRAM_MARCH_LFSR_EN
                lfsr_reg     <= lfsr_start;
`endif
              end
              8'h04: begin
                busy_reg     <= 1'b1;
                rsp_kind_reg <= K_REPORT;
                rsp_idx_reg  <= 3'd0;
                state_reg    <= RESP;
              end
              8'h05: state_reg <= SEED_HI;
              default: begin
                busy_reg     <= 1'b1;
                error_reg    <= 1'b1;
                rsp_kind_reg <= K_BAD;
                rsp_idx_reg  <= 3'd0;
                state_reg    <= RESP;
              end
            endcase
          end
        end
        SEED_HI: if (cmd_valid_i) begin
`ifdef VRAM_MARCH_LFSR_EN
          seed_hi_reg <= cmd_data_i;
`endif
          state_reg <= SEED_LO;
        end
        SEED_LO: if (cmd_valid_i) begin
          seed_lo_reg <= cmd_data_i;
          state_reg   <= IDLE;
        end
        SETUP: begin
          if (cnt_reg == CNT_W'(SETUP_CYCLES - 1)) begin
            cnt_reg   <= '0;
            state_reg <= STROBE;
            if (verify_reg) vrd_n_reg <= 1'b0;
            else            vwr_n_reg <= '0;
          end else begin
            cnt_reg <= cnt_reg + CNT_W'(1);
          end
        end
        STROBE: begin
          if (cnt_reg == CNT_W'(STROBE_CYCLES - 1)) begin
            cnt_reg   <= '0;
            state_reg <= HOLD;
            vrd_n_reg <= 1'b1;
            vwr_n_reg <= '1;
            // Read data is taken on the last cycle the read strobe is low.
            if (verify_reg && (|lane_miss)) begin
              error_reg <= 1'b1;
              if (err_count_reg != 16'hFFFF) err_count_reg <= err_count_reg + 16'd1;
              if (!fail_seen_reg) begin
                fail_seen_reg <= 1'b1;
                fail_addr_reg <= addr_reg;
              end
            end
          end else begin
            cnt_reg <= cnt_reg + CNT_W'(1);
          end
        end
        HOLD: begin
          if (addr_reg == ADDR_LAST) begin
            addr_reg   <= '0;
            vd_reg     <= '0;
            vd_tri_reg <= 1'b1;
            dir_reg    <= 1'b0;
            if (rsp_kind_reg == K_BOTH && !verify_reg) begin
              // Chained verify starts right away, from address 0.
              verify_reg    <= 1'b1;
              err_count_reg <= 16'h0000;
              fail_addr_reg <= '0;
              fail_seen_reg <= 1'b0;
              state_reg     <= SETUP;
`ifdef VRAM_MARCH_LFSR_EN
              lfsr_reg      <= lfsr_start;
`endif
            end else begin
              state_reg <= NEXT;
            end
          end else begin
            addr_reg  <= addr_reg + ADDR_WIDTH'(1);
            vd_reg    <= verify_reg ? '0 : pattern_from(base_next);
            state_reg <= SETUP;
`ifdef VRAM_MARCH_LFSR_EN
            lfsr_reg  <= lfsr_step;
`endif
          end
        end
        NEXT: begin
          rsp_idx_reg <= 3'd0;
          state_reg   <= RESP;
        end
        RESP: begin
          if (rsp_idx_reg == rsp_len) begin
            busy_reg  <= 1'b0;
            state_reg <= IDLE;
          end else if (!rsp_busy_i && !rsp_valid_reg) begin
            // Skipping the cycle after a strobe keeps bytes >= 2 cycles apart.
            rsp_data_reg  <= rsp_byte;
            rsp_valid_reg <= 1'b1;
            rsp_idx_reg   <= rsp_idx_reg + 3'd1;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign rsp_data_o    = rsp_data_reg;
  assign rsp_valid_o   = rsp_valid_reg;
  assign busy_o        = busy_reg;
  assign error_o       = error_reg;
  assign vrd_n_o       = vrd_n_reg;
  assign vwr_n_o       = vwr_n_reg;
  assign va_o          = addr_reg;
  assign vd_o          = vd_reg;
  assign vd_tristate_o = vd_tri_reg;
  assign lvl_vd_dir_o  = dir_reg;

endmodule

// File: tb/tb_vram_march_tester.sv
// Directed bench for vram_march_tester with a 16x16 behavioural RAM and a
// response scoreboard (expected bytes queued when a command is sent).
module tb_vram_march_tester;
  localparam int AW = 4;
  localparam int LN = 2;

  logic            clk = 1'b0;
  logic            reset_n = 1'b0;
  logic [7:0]      cmd_data = 8'h00;
  logic            cmd_valid = 1'b0;
  logic [7:0]      rsp_data_o;
  logic            rsp_valid_o;
  logic            rsp_busy = 1'b0;
  logic            busy_o, error_o, vrd_n_o, vd_tristate_o, lvl_vd_dir_o;
  logic [LN-1:0]   vwr_n_o;
  logic [AW-1:0]   va_o;
  logic [8*LN-1:0] vd_o, vd_i;

  always #5 clk = ~clk;

  vram_march_tester #(.ADDR_WIDTH(AW), .LANES(LN), .SETUP_CYCLES(1), .STROBE_CYCLES(2)) dut (
    .clock(clk), .reset_n(reset_n), .cmd_data_i(cmd_data), .cmd_valid_i(cmd_valid),
    .rsp_data_o(rsp_data_o), .rsp_valid_o(rsp_valid_o), .rsp_busy_i(rsp_busy),
    .busy_o(busy_o), .error_o(error_o), .vrd_n_o(vrd_n_o), .vwr_n_o(vwr_n_o),
    .va_o(va_o), .vd_o(vd_o), .vd_i(vd_i), .vd_tristate_o(vd_tristate_o),
    .lvl_vd_dir_o(lvl_vd_dir_o)
  );

  // Behavioural VRAM: reads drive the bus only while the read strobe is low.
  logic [15:0] ram [16];
  logic        corrupt_go = 1'b0;
  assign vd_i = (!vrd_n_o) ? ram[va_o] : 16'hDEAD;
  always @(posedge clk) begin
    if (corrupt_go) ram[9][15:8] <= ~ram[9][15:8];
    for (int k = 0; k < LN; k++)
      if (!vwr_n_o[k]) ram[va_o][8*k +: 8] <= vd_o[8*k +: 8];
  end

  int         n_vec = 0;
  int         n_err = 0;
  int         cyc = 0;
  int         last_rsp_cyc = -100;
  int         last_fall_cyc = -100;
  int         wr_falls = 0;
  logic       prev_low = 1'b0;
  logic [7:0] exp_q[$];

  function automatic logic [15:0] model_word(input int a, input logic [15:0] seed);
    logic [7:0] base;
`ifdef VRAM_MARCH_LFSR_EN
    logic [15:0] v;
    v = (seed == 16'h0000) ? 16'hACE1 : seed;
    for (int i = 0; i < a; i++) v = {1'b0, v[15:1]} ^ (v[0] ? 16'hB400 : 16'h0000);
    base = v[7:0];
`else
    base = 8'(a) + seed[7:0];
`endif
    return {base + 8'd1, base};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  // One clock: monitor at the falling edge, then return 1 time unit after
  // the rising edge so the caller can drive inputs.
  task automatic tick();
    logic any_low;
    logic [7:0] e;
    @(negedge clk);
    cyc++;
    if (rsp_valid_o) begin
      check("rsp_expected", exp_q.size() != 0, 1);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        check("rsp_byte", rsp_data_o, e);
      end
      check("rsp_gap", (cyc - last_rsp_cyc) >= 2, 1);
      last_rsp_cyc = cyc;
    end
    any_low = !vrd_n_o || (vwr_n_o != 2'b11);
    if (!vrd_n_o) check("rd_bus", {vwr_n_o, vd_tristate_o, lvl_vd_dir_o}, {2'b11, 1'b1, 1'b0});
    if (vwr_n_o != 2'b11)
      check("wr_bus", {vwr_n_o, vd_tristate_o, lvl_vd_dir_o, vrd_n_o}, {2'b00, 1'b0, 1'b1, 1'b1});
    if (any_low && !prev_low) begin
      if (cyc - last_fall_cyc <= 6) check("strobe_period", cyc - last_fall_cyc, 4);
      last_fall_cyc = cyc;
      if (vwr_n_o != 2'b11) wr_falls++;
    end
    prev_low = any_low;
    @(posedge clk);
    #1;
  endtask

  task automatic send_cmd(input logic [7:0] b);
    cmd_data  = b;
    cmd_valid = 1'b1;
    tick();
    cmd_valid = 1'b0;
  endtask

  task automatic drain(input string tag, input int maxc);
    int i = 0;
    while (exp_q.size() != 0 && i < maxc) begin
      tick();
      i++;
    end
    check({tag, "_drain"}, exp_q.size(), 0);
    exp_q.delete();
  endtask

  task automatic wait_idle(input string tag);
    int i = 0;
    while (busy_o && i < 20) begin
      tick();
      i++;
    end
    check({tag, "_busy_low"}, busy_o, 0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_strobes"}, {vrd_n_o, vwr_n_o}, 3'b111);
    check({tag, "_va"}, va_o, 0);
    check({tag, "_vd"}, vd_o, 0);
    check({tag, "_bus_dir"}, {vd_tristate_o, lvl_vd_dir_o}, 2'b10);
    check({tag, "_status"}, {busy_o, rsp_valid_o, error_o}, 3'b000);
    check({tag, "_rsp_data"}, rsp_data_o, 0);
  endtask

  initial begin
    // Reset values
    reset_n = 1'b0;
    repeat (3) tick();
    check_reset_outputs("reset");
    reset_n = 1'b1;
    tick();

    // FILL with seed 0
    wr_falls = 0;
    exp_q.push_back(8'hF1);
    send_cmd(8'h01);
    check("fill_busy_rise", busy_o, 1);
    drain("fill", 200);
    wait_idle("fill");
    check("fill_ram5", ram[5], model_word(5, 16'h0000));
    check("fill_ram15", ram[15], model_word(15, 16'h0000));
    check("fill_writes", wr_falls, 16);

    // SEED 0x1234, then FILL+VERIFY
    send_cmd(8'h05);
    check("seed_busy_low", busy_o, 0);
    send_cmd(8'h12);
    send_cmd(8'h34);
    exp_q.push_back(8'hF1); exp_q.push_back(8'hF2);
    exp_q.push_back(8'h00); exp_q.push_back(8'h00);
    send_cmd(8'h03);
    drain("fv", 400);
    wait_idle("fv");
    check("fv_error", error_o, 0);
    check("fv_ram0", ram[0], model_word(0, 16'h1234));
    check("fv_ram15", ram[15], model_word(15, 16'h1234));

    // FILL, corrupt address 9 lane 1, VERIFY, REPORT
    exp_q.push_back(8'hF1);
    send_cmd(8'h01);
    drain("fill2", 200);
    wait_idle("fill2");
    corrupt_go = 1'b1;
    tick();
    corrupt_go = 1'b0;
    exp_q.push_back(8'hF2); exp_q.push_back(8'h00); exp_q.push_back(8'h01);
    send_cmd(8'h02);
    drain("verify", 200);
    wait_idle("verify");
    check("verify_error", error_o, 1);
    exp_q.push_back(8'hF4); exp_q.push_back(8'h09);
    send_cmd(8'h04);
    drain("report", 50);
    wait_idle("report");

    // Reset clears error; bad opcode, with a FILL dropped while responding
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
    check("rst2_error", error_o, 0);
    tick();
    exp_q.push_back(8'hEE);
    send_cmd(8'h7F);
    send_cmd(8'h01);
    drain("badop", 50);
    repeat (20) tick();
    check("badop_error", error_o, 1);
    check("badop_busy", busy_o, 0);
    // Command sent mid-pass is dropped
    exp_q.push_back(8'hF1);
    send_cmd(8'h01);
    repeat (10) tick();
    send_cmd(8'h02);
    drain("drop", 200);
    repeat (20) tick();
    check("drop_busy", busy_o, 0);

    // Reset in the middle of a fill at address 7
    begin
      int i = 0;
      send_cmd(8'h01);
      while (!(va_o == 4'd7 && vwr_n_o == 2'b00) && i < 200) begin
        tick();
        i++;
      end
      check("reach_addr7", (va_o == 4'd7 && vwr_n_o == 2'b00), 1);
    end
    reset_n = 1'b0;
    tick();
    check_reset_outputs("midrst");
    reset_n = 1'b1;
    repeat (150) tick();
    check("midrst_idle", busy_o, 0);

    // Responses held off by rsp_busy_i, then released
    rsp_busy = 1'b1;
    send_cmd(8'h03);
    repeat (190) tick();
    check("held_busy", busy_o, 1);
    exp_q.push_back(8'hF1); exp_q.push_back(8'hF2);
    exp_q.push_back(8'h00); exp_q.push_back(8'h00);
    rsp_busy = 1'b0;
    drain("held", 50);
    wait_idle("held");
    check("held_error", error_o, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
